// File: rtl/job_seq_pkg.sv
// Shared types and width constants for the job sequencer.
//   seq_state_e : sequencer FSM states
//   job_desc_t  : one queued job (cfg_k value and expected C-stream beat count)
package job_seq_pkg;

  localparam int JS_K_W      = 16;
  localparam int JS_BEAT_W   = 16;
  localparam int JS_JOBS_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_ERR    = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic [JS_K_W-1:0]    k;
    logic [JS_BEAT_W-1:0] beats;
  } job_desc_t;

endpackage

// File: rtl/job_desc_fifo.sv
// Synchronous descriptor queue for the job sequencer.
//   clk, rst_n : clock, async active-low reset (pointers only; storage is not reset)
//   push_i     : write wdata_i; accepted when not full, or when full and popping
//   wdata_i    : descriptor to store
//   pop_i      : advance the read pointer (ignored when empty)
//   rdata_o    : head descriptor (show-ahead, valid when !empty_o)
//   full_o     : DEPTH entries stored
//   empty_o    : no entries stored
module job_desc_fifo
  import job_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  job_desc_t wdata_i,
  input  logic      pop_i,
  output job_desc_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  job_desc_t       mem_q [DEPTH];
  logic [AW:0]     wptr_q, rptr_q;
  logic            do_push, do_pop;

  // Pointers carry one extra MSB so full and empty are distinguishable
  // when the index bits are equal.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/job_sequencer.sv
// Job sequencer: queues job descriptors and runs them one at a time through
// compute_wrapper, issuing one start per job, clearing the sticky done, and
// checking the number of C-stream beats seen during the run.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   desc_valid/ready    : descriptor enqueue handshake (ready = queue not full)
//   desc_k, desc_beats  : job cfg_k and expected C beat count
//   cfg_k               : cfg_k presented to the wrapper for the current job
//   start               : one-cycle launch pulse to the wrapper
//   sw_clear_done       : one-cycle pulse clearing the wrapper's sticky done
//   done                : sticky done from the wrapper
//   c_fire              : C-stream tvalid & tready tap
//   busy                : a job is in flight or descriptors are queued
//   job_done            : one-cycle pulse per completed job
//   err_beats           : sticky, observed beat count differed from expected
//   err_timeout         : sticky, done not seen within TIMEOUT cycles of RUN
//   err_clear           : clears both sticky errors; leaves ERR
//   jobs_completed      : wrapping completed-job count
//
// Descriptor widths (K_W, BEAT_W) must match the job_desc_t fields in job_seq_pkg.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a descriptor; clears a stale done if one is seen
// LAUNCH | start pulse is high this cycle
// RUN    | counting C beats and cycles, waiting for done
// CLEAR  | sw_clear_done + job_done pulse, beat count checked
// DRAIN  | waiting for the wrapper to drop done
// ERR    | timed out; no launches until err_clear
module job_sequencer
  import job_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int K_W     = JS_K_W,
  parameter int BEAT_W  = JS_BEAT_W,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 2000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 desc_valid,
  output logic                 desc_ready,
  input  logic [K_W-1:0]       desc_k,
  input  logic [BEAT_W-1:0]    desc_beats,
  output logic [K_W-1:0]       cfg_k,
  output logic                 start,
  output logic                 sw_clear_done,
  input  logic                 done,
  input  logic                 c_fire,
  output logic                 busy,
  output logic                 job_done,
  output logic                 err_beats,
  output logic                 err_timeout,
  input  logic                 err_clear,
  output logic [JS_JOBS_W-1:0] jobs_completed
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  seq_state_e           state_q;
  logic [K_W-1:0]       cfg_k_q;
  logic [BEAT_W-1:0]    exp_beats_q;
  logic [BEAT_W-1:0]    beat_cnt_q;
  logic [BEAT_W-1:0]    beats_now;
  logic [TO_W-1:0]      to_cnt_q;
  logic                 start_q;
  logic                 sw_clr_q;
  logic                 job_done_q;
  logic                 err_beats_q;
  logic                 err_timeout_q;
  logic [JS_JOBS_W-1:0] jobs_q;

  job_desc_t            desc_in;
  job_desc_t            desc_head;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign desc_in.k     = desc_k;
  assign desc_in.beats = desc_beats;
  assign desc_ready    = !fifo_full;
  assign fifo_push     = desc_valid && !fifo_full;
  assign fifo_pop      = (state_q == ST_IDLE) && !done && !fifo_empty;

  job_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (desc_in),
    .pop_i   (fifo_pop),
    .rdata_o (desc_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Beat count including this cycle's c_fire, saturating at all-ones.
  always_comb begin
    beats_now = beat_cnt_q;
    if (c_fire && (beat_cnt_q != '1)) beats_now = beat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cfg_k_q       <= '0;
      exp_beats_q   <= '0;
      beat_cnt_q    <= '0;
      to_cnt_q      <= '0;
      start_q       <= 1'b0;
      sw_clr_q      <= 1'b0;
      job_done_q    <= 1'b0;
      err_beats_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      jobs_q        <= '0;
    end else begin
      start_q    <= 1'b0;
      sw_clr_q   <= 1'b0;
      job_done_q <= 1'b0;

      // Clear first so a set further down in the same cycle wins.
      if (err_clear) begin
        err_beats_q   <= 1'b0;
        err_timeout_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (done) begin
            // Stale done: clear it, but keep the pulse one cycle wide while
            // the wrapper reacts.
            if (!sw_clr_q) sw_clr_q <= 1'b1;
          end else if (!fifo_empty) begin
            cfg_k_q     <= desc_head.k;
            exp_beats_q <= desc_head.beats;
            beat_cnt_q  <= '0;
            to_cnt_q    <= '0;
            start_q     <= 1'b1;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          beat_cnt_q <= beats_now;
          to_cnt_q   <= to_cnt_q + 1'b1;
          if (done) begin
            sw_clr_q   <= 1'b1;
            job_done_q <= 1'b1;
            state_q    <= ST_CLEAR;
          end else if (to_cnt_q == TO_LAST) begin
            err_timeout_q <= 1'b1;
            sw_clr_q      <= 1'b1;
            state_q       <= ST_ERR;
          end
        end
        ST_CLEAR: begin
          beat_cnt_q <= beats_now;
          jobs_q     <= jobs_q + 1'b1;
          if (beats_now != exp_beats_q) err_beats_q <= 1'b1;
          state_q    <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!done) state_q <= ST_IDLE;
        end
        ST_ERR: begin
          if (err_clear) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_k          = cfg_k_q;
  assign start          = start_q;
  assign sw_clear_done  = sw_clr_q;
  assign job_done       = job_done_q;
  assign err_beats      = err_beats_q;
  assign err_timeout    = err_timeout_q;
  assign jobs_completed = jobs_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_job_sequencer.sv
// Directed bench for job_sequencer with a behavioural compute_wrapper model.
module tb_job_sequencer;

  localparam int DEPTH   = 4;
  localparam int K_W     = 16;
  localparam int BEAT_W  = 16;
  localparam int TO_W    = 16;
  localparam int TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              desc_valid = 1'b0;
  logic              desc_ready;
  logic [K_W-1:0]    desc_k = '0;
  logic [BEAT_W-1:0] desc_beats = '0;
  logic [K_W-1:0]    cfg_k;
  logic              start;
  logic              sw_clear_done;
  logic              done;
  logic              c_fire;
  logic              busy;
  logic              job_done;
  logic              err_beats;
  logic              err_timeout;
  logic              err_clear = 1'b0;
  logic [15:0]       jobs_completed;

  always #5 clk = ~clk;

  job_sequencer #(
    .DEPTH(DEPTH), .K_W(K_W), .BEAT_W(BEAT_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_k(desc_k), .desc_beats(desc_beats),
    .cfg_k(cfg_k), .start(start), .sw_clear_done(sw_clear_done),
    .done(done), .c_fire(c_fire),
    .busy(busy), .job_done(job_done),
    .err_beats(err_beats), .err_timeout(err_timeout), .err_clear(err_clear),
    .jobs_completed(jobs_completed)
  );

  int checks = 0;
  int failures = 0;
  int starts = 0;
  logic [K_W-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- compute_wrapper model ----------------
  int emit_beats = 8;
  bit hang_done = 1'b0;
  bit bp_en = 1'b0;
  bit stall_en = 1'b0;
  bit stale_req = 1'b0;
  bit w_active;
  int w_left;
  int w_cyc;

  function automatic bit ready_now(input int cyc);
    if (stall_en && cyc >= 3 && cyc < 13) return 1'b0;
    if (bp_en) return ($urandom_range(0, 1) == 1);
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_active <= 1'b0;
      w_left   <= 0;
      w_cyc    <= 0;
      c_fire   <= 1'b0;
      done     <= 1'b0;
    end else begin
      c_fire <= 1'b0;
      if (sw_clear_done) done <= 1'b0;
      if (stale_req) done <= 1'b1;
      if (start) begin
        w_active <= 1'b1;
        w_left   <= emit_beats;
        w_cyc    <= 0;
      end else if (w_active) begin
        w_cyc <= w_cyc + 1;
        if (w_left == 0) begin
          w_active <= 1'b0;
          if (!hang_done) done <= 1'b1;
        end else if (ready_now(w_cyc)) begin
          c_fire <= 1'b1;
          w_left <= w_left - 1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic done_prev = 1'b0;
  bit   clr_due = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
      clr_due   = 1'b0;
    end else begin
      if (clr_due) chk("clr_after_done", sw_clear_done, 1);
      clr_due   = done && !done_prev;
      done_prev = done;
      if (start) begin
        starts++;
        chk("start_while_done", done, 0);
        chk("start_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) chk("cfg_k_order", cfg_k, sb_q.pop_front());
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic push(input logic [K_W-1:0] k, input logic [BEAT_W-1:0] b);
    int n = 0;
    while (desc_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("push_ready", desc_ready, 1);
    desc_valid = 1'b1;
    desc_k     = k;
    desc_beats = b;
    sb_q.push_back(k);
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin @(negedge clk); n++; end
    chk(tag, busy, 0);
  endtask

  task automatic wait_sig_start(input string tag, input int bound);
    int n = 0;
    while (start !== 1'b1 && n < bound) begin @(negedge clk); n++; end
    chk(tag, start, 1);
  endtask

  task automatic wait_job_done(input string tag, input int bound);
    int n = 0;
    while (job_done !== 1'b1 && n < bound) begin @(negedge clk); n++; end
    chk(tag, job_done, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_desc_ready"}, desc_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_sw_clear_done"}, sw_clear_done, 0);
    chk({tag, "_job_done"}, job_done, 0);
    chk({tag, "_err_beats"}, err_beats, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_jobs_completed"}, jobs_completed, 0);
    chk({tag, "_cfg_k"}, cfg_k, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;

    // Reset state
    idle_cycles(2);
    check_reset_values("rst");
    rst_n = 1'b1;
    idle_cycles(2);

    // Single job k=4, beats=8
    push(16'd4, 16'd8);
    wait_job_done("t1_job_done", 200);
    wait_idle("t1_idle", 50);
    chk("t1_starts", starts, 1);
    chk("t1_jobs", jobs_completed, 1);
    chk("t1_err_beats", err_beats, 0);

    // Three back-to-back descriptors
    push(16'd4, 16'd8);
    push(16'd8, 16'd8);
    push(16'd16, 16'd8);
    wait_idle("t2_idle", 500);
    chk("t2_starts", starts, 4);
    chk("t2_jobs", jobs_completed, 4);
    chk("t2_err_beats", err_beats, 0);

    // Random backpressure plus a 10-cycle stall
    bp_en = 1'b1;
    stall_en = 1'b1;
    push(16'd5, 16'd8);
    wait_idle("t3_idle", 400);
    bp_en = 1'b0;
    stall_en = 1'b0;
    chk("t3_jobs", jobs_completed, 5);
    chk("t3_err_beats", err_beats, 0);

    // Short job: 7 beats against 8 expected
    emit_beats = 7;
    push(16'd6, 16'd8);
    wait_job_done("t4_job_done", 200);
    @(negedge clk);
    chk("t4_err_beats_set", err_beats, 1);
    emit_beats = 8;
    push(16'd7, 16'd8);
    wait_idle("t4_idle", 200);
    chk("t4_starts", starts, 7);
    chk("t4_jobs", jobs_completed, 7);
    chk("t4_err_beats_sticky", err_beats, 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("t4_err_beats_clr", err_beats, 0);

    // Timeout with a second job queued behind it
    hang_done = 1'b1;
    push(16'd9, 16'd8);
    push(16'd10, 16'd8);
    wait_sig_start("t5_start", 50);
    n = 0;
    do begin @(negedge clk); n++; end while (err_timeout !== 1'b1 && n < 200);
    chk("t5_timeout_cycle", n, 51);
    chk("t5_clr_on_err", sw_clear_done, 1);
    idle_cycles(20);
    chk("t5_no_start_in_err", starts, 8);
    chk("t5_busy_in_err", busy, 1);
    chk("t5_jobs", jobs_completed, 7);
    hang_done = 1'b0;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("t5_err_timeout_clr", err_timeout, 0);
    wait_idle("t5_idle", 200);
    chk("t5_starts_after", starts, 9);
    chk("t5_jobs_after", jobs_completed, 8);

    // Stale done while idle
    stale_req = 1'b1;
    @(negedge clk);
    stale_req = 1'b0;
    idle_cycles(6);
    chk("t6_done_cleared", done, 0);
    chk("t6_no_start", starts, 9);
    chk("t6_busy", busy, 0);

    // Fill the queue behind a long job, then reset mid-RUN
    emit_beats = 40;
    push(16'd11, 16'd40);
    wait_sig_start("t7_start", 50);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push(K_W'(12 + i), 16'd40);
    chk("t7_full_ready", desc_ready, 0);
    chk("t7_full_busy", busy, 1);
    desc_valid = 1'b1;
    desc_k     = 16'd99;
    desc_beats = 16'd1;
    idle_cycles(3);
    chk("t7_still_full", desc_ready, 0);
    desc_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("t7_rst");
    sb_q.delete();
    idle_cycles(2);
    rst_n = 1'b1;
    emit_beats = 8;
    idle_cycles(8);
    chk("t7_post_busy", busy, 0);
    chk("t7_post_ready", desc_ready, 1);
    chk("t7_post_starts", starts, 10);
    chk("t7_post_jobs", jobs_completed, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
